// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: opcodes, FSM encoding and error-bit index shared by the sequencer and its users
package alu_op_sequencer_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_MOD  = 4'd4;
    localparam logic [3:0] OP_LAST = OP_MOD;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int ERR_DIV0 = 1;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: handshake front-end that drives a combinational ALU, waits for it to settle and returns the result
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DW            = 16,
    parameter int RW            = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERRCW         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DW-1:0]    cmd_a,
    input  logic [DW-1:0]    cmd_b,
    input  logic [3:0]       cmd_op,
    input  logic             cmd_chain,
    output logic [DW-1:0]    alu_in1,
    output logic [DW-1:0]    alu_in2,
    output logic [3:0]       alu_op,
    input  logic [RW-1:0]    alu_out,
    input  logic [1:0]       alu_err,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RW-1:0]    rsp_result,
    output logic [1:0]       rsp_err,
    output logic             rsp_illegal,
    output logic [ERRCW-1:0] err_count,
    output logic             busy
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    in1_q, in1_d, in2_q, in2_d, last_q, last_d;
    logic [3:0]       op_q, op_d;
    logic [RW-1:0]    res_q, res_d;
    logic [1:0]       err_q, err_d;
    logic             ill_q, ill_d;
    logic [ERRCW-1:0] ecnt_q, ecnt_d, ecnt_inc;

    assign ecnt_inc    = &ecnt_q ? ecnt_q : ecnt_q + 1'b1;
    assign cmd_ready   = state_q == S_IDLE;
    assign busy        = state_q != S_IDLE;
    assign rsp_valid   = state_q == S_RESP;
    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_op      = op_q;
    assign rsp_result  = res_q;
    assign rsp_err     = err_q;
    assign rsp_illegal = ill_q;
    assign err_count   = ecnt_q;

    // Next state: accept in IDLE, count down the settle window, hold the response until taken
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        ill_d   = ill_q;
        last_d  = last_q;
        ecnt_d  = ecnt_q;
        if (state_q == S_IDLE && cmd_valid) begin
            if (op_legal(cmd_op)) begin
                in1_d   = cmd_chain ? last_q : cmd_a;
                in2_d   = cmd_b;
                op_d    = cmd_op;
                cnt_d   = CW'(SETTLE_CYCLES);
                state_d = S_SETTLE;
            end else begin
                res_d   = '0;
                err_d   = '0;
                ill_d   = 1'b1;
                ecnt_d  = ecnt_inc;
                state_d = S_RESP;
            end
        end else if (state_q == S_SETTLE) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                res_d   = alu_out;
                last_d  = alu_out[DW-1:0];
                err_d   = alu_err;
                ill_d   = 1'b0;
                ecnt_d  = alu_err != 2'b00 ? ecnt_inc : ecnt_q;
                state_d = S_RESP;
            end
        end else if (state_q == S_RESP && rsp_ready) begin
            state_d = S_IDLE;
        end
    end

    // State registers; reset drops any in-flight command
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            err_q   <= '0;
            ill_q   <= 1'b0;
            last_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            ill_q   <= ill_d;
            last_q  <= last_d;
            ecnt_q  <= ecnt_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scoreboard bench for the ALU sequencer with a behavioural ALU attached
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_chain = 1'b0;
    logic [15:0] cmd_a = '0, cmd_b = '0, alu_in1, alu_in2;
    logic [3:0]  cmd_op = '0, alu_op;
    logic [31:0] alu_out, rsp_result;
    logic [1:0]  alu_err, rsp_err;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_illegal, busy;
    logic [7:0]  err_count;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  err;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   vecs = 0;
    int   fails = 0;
    int   ecnt_m = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DW(16), .RW(32), .SETTLE_CYCLES(SETTLE), .ERRCW(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_err(alu_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_illegal(rsp_illegal),
        .err_count(err_count), .busy(busy)
    );

    // Behavioural BreadBoard ALU: unsigned 32-bit results, divide/modulo by zero flags ERR_DIV0
    always_comb begin
        alu_out = '0;
        alu_err = '0;
        case (alu_op)
            OP_ADD: alu_out = 32'(alu_in1) + 32'(alu_in2);
            OP_SUB: alu_out = 32'(alu_in1) - 32'(alu_in2);
            OP_MUL: alu_out = 32'(alu_in1) * 32'(alu_in2);
            OP_DIV: if (alu_in2 == 0) alu_err[ERR_DIV0] = 1'b1; else alu_out = 32'(alu_in1 / alu_in2);
            OP_MOD: if (alu_in2 == 0) alu_err[ERR_DIV0] = 1'b1; else alu_out = 32'(alu_in1 % alu_in2);
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                         input logic chain, input logic [31:0] exp_res, input logic [1:0] exp_err);
        exp_t e;
        logic legal;
        legal = op <= 4'd4;
        e.res = legal ? exp_res : 32'd0;
        e.err = legal ? exp_err : 2'd0;
        e.ill = !legal;
        e.lat = legal ? SETTLE + 1 : 1;
        if ((!legal || exp_err != 0) && ecnt_m != 255) ecnt_m++;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain; cmd_valid = 1'b1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        q.push_back(e);
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = q.pop_front();
        chk("latency", 32'(lat), 32'(e.lat));
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
        chk("err_count", 32'(err_count), 32'(ecnt_m));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_result", rsp_result, e.res);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("idle_after_rsp", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_alu_in1", 32'(alu_in1), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);

        issue(16'd11, 16'd15, OP_ADD, 1'b0, 32'd26, 2'd0);
        chk("settle_alu_in1", 32'(alu_in1), 32'd11);
        chk("settle_alu_op", 32'(alu_op), 32'(OP_ADD));
        collect(0);
        issue(16'd32000, 16'd16000, OP_MUL, 1'b0, 32'd512000000, 2'd0); collect(0);
        issue(16'd11, 16'd15, OP_SUB, 1'b0, 32'hFFFFFFFC, 2'd0);         collect(0);
        issue(16'd11, 16'd0, OP_DIV, 1'b0, 32'd0, 2'b10);                collect(0);
        issue(16'd1, 16'd2, 4'd9, 1'b0, 32'd0, 2'd0);                    collect(0);
        chk("alu_op_kept_after_illegal", 32'(alu_op), 32'(OP_DIV));
        issue(16'd23, 16'd5, OP_MOD, 1'b0, 32'd3, 2'd0);                 collect(0);

        issue(16'd5, 16'd6, OP_ADD, 1'b0, 32'd11, 2'd0);                 collect(0);
        issue(16'd0, 16'd0, 4'd15, 1'b0, 32'd0, 2'd0);                   collect(0);
        issue(16'hDEAD, 16'd3, OP_MUL, 1'b1, 32'd33, 2'd0);              collect(0);
        issue(16'd0, 16'd100, OP_ADD, 1'b1, 32'd133, 2'd0);              collect(0);

        issue(16'd7, 16'd8, OP_MUL, 1'b0, 32'd56, 2'd0);
        cmd_a = 16'd99; cmd_b = 16'd1; cmd_op = OP_ADD; cmd_chain = 1'b0; cmd_valid = 1'b1;
        collect(10);
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_stray_rsp", 32'(rsp_valid), 32'd0);
        end

        issue(16'd1, 16'd2, OP_ADD, 1'b0, 32'd3, 2'd0);
        chk("busy_in_settle", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_in1", 32'(alu_in1), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        q.delete();
        ecnt_m = 0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        issue(16'd0, 16'd4, OP_ADD, 1'b1, 32'd4, 2'd0); collect(0);

        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) issue(16'(i), 16'd0, OP_MOD, 1'b0, 32'd0, 2'b10);
            else            issue(16'(i), 16'd0, 4'd12, 1'b0, 32'd0, 2'd0);
            collect(0);
        end
        chk("err_count_saturated", 32'(err_count), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
